// File: rtl/tag_tx_frame_scheduler.sv
// Tag-chip transmit frame sequencer: pilot preamble, serialized data bits, guard interval.
// Optional loop mode replays the latched frame back-to-back until loop drops or abort.
module tag_tx_frame_scheduler #(
    parameter int unsigned TX_BITS_WIDTH = 128,
    parameter int unsigned BIT_CNT_WIDTH = 7,
    parameter int unsigned LEN_WIDTH     = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     loop,
    input  logic [TX_BITS_WIDTH-1:0] tx_bits,
    input  logic [BIT_CNT_WIDTH-1:0] ntx_bits,
    input  logic [LEN_WIDTH-1:0]     symb_len,
    input  logic [LEN_WIDTH-1:0]     pilot_len,
    input  logic [LEN_WIDTH-1:0]     guard_len,
    output logic [1:0]               mtx_state,
    output logic                     pilot_en,
    output logic                     tx_en,
    output logic                     tx_bit,
    output logic [BIT_CNT_WIDTH-1:0] ntx_bits_cnt,
    output logic                     hop_clk,
    output logic                     hop_rst,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPilot = 2'd1,
        StData  = 2'd2,
        StGuard = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [TX_BITS_WIDTH-1:0] shift_q, shift_d;
    logic [TX_BITS_WIDTH-1:0] copy_q, copy_d;
    logic [BIT_CNT_WIDTH-1:0] ntx_q, ntx_d;
    logic [LEN_WIDTH-1:0]     symb_q, symb_d;
    logic [LEN_WIDTH-1:0]     pilot_q, pilot_d;
    logic [LEN_WIDTH-1:0]     guard_q, guard_d;
    logic                     done_d;
    logic                     pilot_en_q, tx_en_q, tx_bit_q, hop_clk_q, hop_rst_q, busy_q, done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + LEN_WIDTH'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        copy_d    = copy_q;
        ntx_d     = ntx_q;
        symb_d    = symb_q;
        pilot_d   = pilot_q;
        guard_d   = guard_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (start && (ntx_bits != '0) && (symb_len != '0)) begin
                    shift_d = tx_bits;
                    copy_d  = tx_bits;
                    ntx_d   = ntx_bits;
                    symb_d  = symb_len;
                    pilot_d = pilot_len;
                    guard_d = guard_len;
                    state_d = (pilot_len != '0) ? StPilot : StData;
                end
            end
            StPilot: begin
                if (cnt_q == pilot_q - LEN_WIDTH'(1)) begin
                    cnt_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (cnt_q == symb_q - LEN_WIDTH'(1)) begin
                    cnt_d = '0;
                    if (bit_cnt_q == ntx_q - BIT_CNT_WIDTH'(1)) begin
                        if (guard_q != '0) begin
                            state_d = StGuard;
                        end else begin
                            state_d   = StIdle;
                            bit_cnt_d = '0;
                            done_d    = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
                    end
                end
            end
            StGuard: begin
                if (cnt_q == guard_q - LEN_WIDTH'(1)) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    done_d    = 1'b1;
                    if (loop) begin
                        shift_d = copy_q;
                        state_d = (pilot_q != '0) ? StPilot : StData;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
        endcase

        // Abort wins over every transition; in IDLE it also blocks a coincident start.
        if (abort) begin
            state_d   = StIdle;
            cnt_d     = '0;
            bit_cnt_d = '0;
            shift_d   = shift_q;
            copy_d    = copy_q;
            ntx_d     = ntx_q;
            symb_d    = symb_q;
            pilot_d   = pilot_q;
            guard_d   = guard_q;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            copy_q     <= '0;
            ntx_q      <= '0;
            symb_q     <= '0;
            pilot_q    <= '0;
            guard_q    <= '0;
            pilot_en_q <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_bit_q   <= 1'b0;
            hop_clk_q  <= 1'b0;
            hop_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            copy_q     <= copy_d;
            ntx_q      <= ntx_d;
            symb_q     <= symb_d;
            pilot_q    <= pilot_d;
            guard_q    <= guard_d;
            // Outputs are decoded from next state so they line up with mtx_state.
            pilot_en_q <= (state_d == StPilot);
            tx_en_q    <= (state_d == StData);
            tx_bit_q   <= (state_d == StData) && shift_d[0];
            hop_clk_q  <= (state_d == StData) && (cnt_d == '0);
            hop_rst_q  <= (state_d == StIdle);
            busy_q     <= (state_d != StIdle);
            done_q     <= done_d;
        end
    end

    assign mtx_state    = state_q;
    assign pilot_en     = pilot_en_q;
    assign tx_en        = tx_en_q;
    assign tx_bit       = tx_bit_q;
    assign ntx_bits_cnt = bit_cnt_q;
    assign hop_clk      = hop_clk_q;
    assign hop_rst      = hop_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_tag_tx_frame_scheduler.sv
// Bench for tag_tx_frame_scheduler: per-cycle comparison against a frame-level reference
// that expands each frame into its pilot / data / guard cycle sequence.
module tb_tag_tx_frame_scheduler;

    localparam int TXW = 128;
    localparam int BCW = 7;
    localparam int LW  = 24;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           loop = 1'b0;
    logic [TXW-1:0] tx_bits = '0;
    logic [BCW-1:0] ntx_bits = '0;
    logic [LW-1:0]  symb_len = '0;
    logic [LW-1:0]  pilot_len = '0;
    logic [LW-1:0]  guard_len = '0;
    logic [1:0]     mtx_state;
    logic           pilot_en, tx_en, tx_bit, hop_clk, hop_rst, busy, done;
    logic [BCW-1:0] ntx_bits_cnt;
    logic [15:0]    obs;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    tag_tx_frame_scheduler dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .loop(loop),
        .tx_bits(tx_bits), .ntx_bits(ntx_bits), .symb_len(symb_len), .pilot_len(pilot_len),
        .guard_len(guard_len), .mtx_state(mtx_state), .pilot_en(pilot_en), .tx_en(tx_en),
        .tx_bit(tx_bit), .ntx_bits_cnt(ntx_bits_cnt), .hop_clk(hop_clk), .hop_rst(hop_rst),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign obs = {mtx_state, pilot_en, tx_en, tx_bit, ntx_bits_cnt, hop_clk, hop_rst, busy, done};

    // Expected output vector for one cycle, derived from the state name and the bit being sent.
    function automatic logic [15:0] mk(input int st, input logic b, input int idx,
                                       input logic hop, input logic dn);
        logic [1:0] s;
        logic [6:0] c;
        s = 2'(st);
        c = 7'(idx);
        return {s, s == 2'd1, s == 2'd2, (s == 2'd2) & b, c, hop, s == 2'd0, s != 2'd0, dn};
    endfunction

    task automatic build(input logic [127:0] bits, input int ntx, input int symb,
                         input int pilot, input int guard, input int nfr);
        logic first;
        exp_q.delete();
        for (int f = 0; f < nfr; f++) begin
            first = (f > 0);
            for (int c = 0; c < pilot; c++) begin
                exp_q.push_back(mk(1, 1'b0, 0, 1'b0, first));
                first = 1'b0;
            end
            for (int b = 0; b < ntx; b++) begin
                for (int c = 0; c < symb; c++) begin
                    exp_q.push_back(mk(2, bits[b], b, c == 0, first));
                    first = 1'b0;
                end
            end
            for (int c = 0; c < guard; c++) begin
                exp_q.push_back(mk(3, 1'b0, ntx - 1, 1'b0, first));
                first = 1'b0;
            end
        end
        exp_q.push_back(mk(0, 1'b0, 0, 1'b0, 1'b1));
    endtask

    task automatic run_seq(input string name, input logic [127:0] bits, input int ntx,
                           input int symb, input int pilot, input int guard, input int nfr,
                           input int restart_at, input int abort_at, input int reset_at);
        int          flen;
        int          last_start;
        int          hops;
        bit          cut;
        logic [15:0] idle_v;
        idle_v = mk(0, 1'b0, 0, 1'b0, 1'b0);
        build(bits, ntx, symb, pilot, guard, nfr);
        flen = pilot + ntx * symb + guard;
        last_start = (nfr - 1) * flen;
        hops = 0;
        cut = 1'b0;
        @(negedge clk);
        tx_bits = bits;
        ntx_bits = 7'(ntx);
        symb_len = 24'(symb);
        pilot_len = 24'(pilot);
        guard_len = 24'(guard);
        loop = (nfr > 1);
        start = 1'b1;
        for (int i = 0; i < exp_q.size() && !cut; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                tx_bits = {$urandom, $urandom, $urandom, $urandom};
                ntx_bits = 7'($urandom_range(1, 127));
                symb_len = 24'($urandom_range(1, 9));
                pilot_len = 24'($urandom_range(0, 9));
                guard_len = 24'($urandom_range(0, 9));
            end
            if (i == 0 || i == restart_at + 1) start = 1'b0;
            if (i == restart_at) start = 1'b1;
            if (nfr > 1 && i == last_start) loop = 1'b0;
            n_tests++;
            if (obs !== exp_q[i])
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs, exp_q[i]);
            if (obs !== exp_q[i]) n_fail++;
            hops += int'(hop_clk);
            if (i == abort_at) begin
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                cut = 1'b1;
            end
            if (i == reset_at) begin
                reset_n = 1'b0;
                #1;
                n_tests++;
                if (obs !== idle_v) begin
                    $display("FAIL %s async reset: got %h expected %h", name, obs, idle_v);
                    n_fail++;
                end
                @(posedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                cut = 1'b1;
            end
        end
        if (!cut) begin
            n_tests++;
            if (hops != ntx * nfr) begin
                $display("FAIL %s hop_clk count: got %0d expected %0d", name, hops, ntx * nfr);
                n_fail++;
            end
        end
        // Afterwards the block must sit idle with no stray done.
        for (int k = 0; k < 3; k++) begin
            if (k > 0 || cut) begin
                @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
            n_tests++;
            if (obs !== idle_v) begin
                $display("FAIL %s idle after: got %h expected %h", name, obs, idle_v);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (obs !== mk(0, 1'b0, 0, 1'b0, 1'b0)) begin
            $display("FAIL reset values: got %h expected %h", obs, mk(0, 1'b0, 0, 1'b0, 1'b0));
            n_fail++;
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_long_frame();
        logic [127:0] b;
        b = '0;
        b[79:0] = 80'h0AAAAAAAAAAAAAAAAAAA;
        run_seq("long_frame", b, 80, 4, 8, 2, 1, -1, -1, -1);
    endtask

    task automatic test_short_frame();
        logic [127:0] b;
        b = {125'($urandom), 3'b101};
        run_seq("short_frame", b, 3, 1, 0, 0, 1, -1, -1, -1);
    endtask

    task automatic test_reject();
        logic [15:0] idle_v;
        idle_v = mk(0, 1'b0, 0, 1'b0, 1'b0);
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            tx_bits = {$urandom, $urandom, $urandom, $urandom};
            ntx_bits = (v == 0) ? 7'd0 : 7'd5;
            symb_len = (v == 1) ? 24'd0 : 24'd2;
            pilot_len = 24'd1;
            guard_len = 24'd1;
            abort = (v == 2);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (obs !== idle_v) begin
                    $display("FAIL reject variant %0d: got %h expected %h", v, obs, idle_v);
                    n_fail++;
                end
                @(posedge clk);
                #1;
            end
        end
        run_seq("start_while_busy", {$urandom, $urandom, $urandom, $urandom}, 9, 2, 3, 2, 1,
                5, -1, -1);
    endtask

    task automatic test_abort();
        logic [127:0] b;
        b = '0;
        b[79:0] = 80'h0AAAAAAAAAAAAAAAAAAA;
        run_seq("abort_data", b, 80, 4, 8, 2, 1, -1, 8 + 5 * 4, -1);
    endtask

    task automatic test_loop();
        logic [127:0] b;
        b = {48'($urandom), 80'h0AAAAAAAAAAAAAAAAAAA};
        run_seq("loop3", b, 80, 4, 8, 2, 3, -1, -1, -1);
    endtask

    task automatic test_reset_mid_pilot();
        run_seq("reset_pilot", {$urandom, $urandom, $urandom, $urandom}, 10, 3, 8, 2, 1,
                -1, -1, 3);
    endtask

    task automatic test_random();
        int ntx, symb, pilot, guard, nfr, flen;
        for (int k = 0; k < 8; k++) begin
            ntx = $urandom_range(1, 20);
            symb = $urandom_range(1, 4);
            pilot = $urandom_range(0, 5);
            guard = $urandom_range(0, 4);
            nfr = (guard > 0 && (k % 2 == 1)) ? 2 : 1;
            flen = pilot + ntx * symb + guard;
            run_seq("random", {$urandom, $urandom, $urandom, $urandom}, ntx, symb, pilot, guard,
                    nfr, $urandom_range(0, flen - 1), -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_long_frame();
        test_short_frame();
        test_reject();
        test_abort();
        test_loop();
        test_reset_mid_pilot();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
